// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator input front end.
//   opcode_t       : ALU operation selected from sw[1:0] on the opcode step
//   entry_state_t  : entry sequencer state; the encoding drives status LEDs
//   DATA_W_DEF     : default operand width (matches the 4-bit operand bus)
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    S_OP1  = 2'd0,
    S_OP2  = 2'd1,
    S_OPC  = 2'd2,
    S_SHOW = 2'd3
  } entry_state_t;

  // Opcode field taken from the two low switches.
  function automatic opcode_t opcode_from_sw(input logic [1:0] sw_lo);
    return opcode_t'(sw_lo);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises one raw asynchronous push-button, debounces it and emits a
// single-cycle pulse on each accepted press (release produces nothing).
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   i_raw    : raw, bouncy, asynchronous button level
//   o_pulse  : one-cycle pulse when the debounced level rises
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_d;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchroniser; r_sync2 is the metastability-safe level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The level must differ from the accepted level for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_db_d <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Rising edge of the debounced level; both terms are registered.
  assign o_pulse = r_db & ~r_db_d;

endmodule

// File: rtl/calc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// calc_entry_ctrl
// Input-side front end of the calculator: debounces the enter, mode and
// clear buttons and sequences operand1 -> operand2 -> opcode entry from the
// slide switches.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   sw              : slide switches, sampled only on an accepted enter
//   btn_*_raw       : raw asynchronous buttons (enter, mode, clear)
//   operand1/2      : captured operands
//   opcode          : captured operation (sw[1:0])
//   operands_valid  : one-cycle pulse when the opcode step completes
//   mode_change     : one-cycle pulse per accepted mode press
//   entry_state     : registered sequencer state for status LEDs
// ---------------------------------------------------------------------------
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DATA_W          = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_enter_raw,
  input  logic              btn_mode_raw,
  input  logic              btn_clear_raw,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [1:0]        opcode,
  output logic              operands_valid,
  output logic              mode_change,
  output logic [1:0]        entry_state
);

  logic w_enter;
  logic w_mode;
  logic w_clear;

  entry_state_t      r_state;
  logic [DATA_W-1:0] r_operand1;
  logic [DATA_W-1:0] r_operand2;
  opcode_t           r_opcode;
  logic              r_valid;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_enter_raw),
    .o_pulse (w_enter)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_mode_raw),
    .o_pulse (w_mode)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_clear_raw),
    .o_pulse (w_clear)
  );

  // Entry sequencer. Clear is checked first so a same-cycle enter is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_OP1;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_opcode   <= OP_ADD;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_clear) begin
        r_state    <= S_OP1;
        r_operand1 <= '0;
        r_operand2 <= '0;
        r_opcode   <= OP_ADD;
      end else if (w_enter) begin
        case (r_state)
          S_OP1: begin
            r_operand1 <= sw;
            r_state    <= S_OP2;
          end
          S_OP2: begin
            r_operand2 <= sw;
            r_state    <= S_OPC;
          end
          S_OPC: begin
            r_opcode <= opcode_from_sw(sw[1:0]);
            r_valid  <= 1'b1;
            r_state  <= S_SHOW;
          end
          default: begin
            // S_SHOW: operands stay until overwritten by the next entry.
            r_state <= S_OP1;
          end
        endcase
      end
    end
  end

  assign operand1       = r_operand1;
  assign operand2       = r_operand2;
  assign opcode         = r_opcode;
  assign operands_valid = r_valid;
  assign entry_state    = r_state;
  // Mode presses bypass the sequencer entirely.
  assign mode_change    = w_mode;

endmodule
